// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg: shared definitions for the registered Hack ALU stage.
//   - DATA_W            : datapath width (16 only)
//   - CTRL_*            : bit positions inside the 6-bit control word {zx,nx,zy,ny,f,no}
//   - ALU_*             : named Hack control words
//   - alu_res_t         : one buffered result {r, zr, ng}
package alu_stage_pkg;

  localparam int DATA_W = 16;

  localparam int CTRL_ZX = 5;
  localparam int CTRL_NX = 4;
  localparam int CTRL_ZY = 3;
  localparam int CTRL_NY = 2;
  localparam int CTRL_F  = 1;
  localparam int CTRL_NO = 0;

  localparam logic [5:0] ALU_ZERO    = 6'b101010;
  localparam logic [5:0] ALU_ONE     = 6'b111111;
  localparam logic [5:0] ALU_NEG1    = 6'b111010;
  localparam logic [5:0] ALU_X       = 6'b001100;
  localparam logic [5:0] ALU_Y       = 6'b110000;
  localparam logic [5:0] ALU_NOTX    = 6'b001101;
  localparam logic [5:0] ALU_XPLUSY  = 6'b000010;
  localparam logic [5:0] ALU_XMINUSY = 6'b010011;
  localparam logic [5:0] ALU_YMINUSX = 6'b000111;
  localparam logic [5:0] ALU_XANDY   = 6'b000000;
  localparam logic [5:0] ALU_XORY    = 6'b010101;

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic              zr;
    logic              ng;
  } alu_res_t;

endpackage

// File: rtl/alu_stage_hack_alu.sv
// hack_alu: combinational Hack ALU core.
//   x_i, y_i : operands
//   ctrl_i   : {zx,nx,zy,ny,f,no}
//   res_o    : result r with zero (zr) and negative (ng) flags
module hack_alu
  import alu_stage_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  logic [5:0]        ctrl_i,
  output alu_res_t          res_o
);

  logic [DATA_W-1:0] xz, xn, yz, yn, f_and, f_add, f_sel, r;

  // Operand preconditioning: zero, then optional invert.
  assign xz    = ctrl_i[CTRL_ZX] ? '0 : x_i;
  assign xn    = ctrl_i[CTRL_NX] ? ~xz : xz;
  assign yz    = ctrl_i[CTRL_ZY] ? '0 : y_i;
  assign yn    = ctrl_i[CTRL_NY] ? ~yz : yz;

  assign f_and = xn & yn;
  assign f_add = xn + yn;  // carry out discarded, mod 2^16
  assign f_sel = ctrl_i[CTRL_F] ? f_add : f_and;
  assign r     = ctrl_i[CTRL_NO] ? ~f_sel : f_sel;

  assign res_o = '{r: r, zr: (r == '0), ng: r[DATA_W-1]};

endmodule

// File: rtl/alu_stage.sv
// alu_stage: registered Hack ALU with valid/ready handshake and a 2-entry
// result FIFO, plus a wrapping count of results consumed downstream.
//   clk, reset          : clock, async active-high reset
//   in_valid/in_ready   : operand beat handshake (x, y, ctrl)
//   out_valid/out_ready : result handshake (out, zr, ng = FIFO head)
//   op_count            : results popped so far, wraps at 0xFFFF
module alu_stage
  import alu_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic [15:0]      op_count
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  alu_res_t              alu_res;
  alu_res_t [DEPTH-1:0]  mem_q;
  alu_res_t              hold_q;   // last popped result, shown while empty
  alu_res_t              head;
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [15:0]           opc_q, opc_d;
  logic                  acc, pop;

  hack_alu u_alu (
    .x_i    (x),
    .y_i    (y),
    .ctrl_i (ctrl),
    .res_o  (alu_res)
  );

  // Ready depends on occupancy only; held low while reset is asserted so
  // nothing is offered into a buffer that is being cleared.
  assign in_ready  = ~reset & (cnt_q < FULL);
  assign out_valid = (cnt_q != 2'd0);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wptr_d = wptr_q ^ acc;
    rptr_d = rptr_q ^ pop;
    cnt_d  = cnt_q + {1'b0, acc} - {1'b0, pop};
    opc_d  = opc_q + {15'd0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q  <= '0;
      hold_q <= '0;
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
      opc_q  <= 16'd0;
    end else begin
      if (acc) mem_q[wptr_q] <= alu_res;
      if (pop) hold_q <= mem_q[rptr_q];
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      opc_q  <= opc_d;
    end
  end

  // Empty buffer: keep presenting the most recently consumed result.
  assign head     = out_valid ? mem_q[rptr_q] : hold_q;
  assign out      = head.r;
  assign zr       = head.zr;
  assign ng       = head.ng;
  assign op_count = opc_q;

endmodule

// File: tb/tb_alu_stage.sv
module tb_alu_stage;
  import alu_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [15:0] x = '0, y = '0;
  logic [5:0]  ctrl = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [15:0] out;
  logic        zr, ng;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [5:0] c, input logic [15:0] xv, input logic [15:0] yv);
    ctrl = c; x = xv; y = yv; in_valid = 1'b1;
  endtask

  initial begin
    #12 reset = 1'b0;
    tick();
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out",       32'(out),       32'd0);
    chk("rst zr",        32'(zr),        32'd0);
    chk("rst ng",        32'(ng),        32'd0);
    chk("rst op_count",  32'(op_count),  32'd0);
    chk("rst in_ready",  32'(in_ready),  32'd1);

    // single AND beat
    out_ready = 1'b1;
    beat(ALU_XANDY, 16'h0005, 16'h0003);
    tick(); in_valid = 1'b0;
    chk("and out",       32'(out),       32'h0001);
    chk("and zr",        32'(zr),        32'd0);
    chk("and ng",        32'(ng),        32'd0);
    chk("and out_valid", 32'(out_valid), 32'd1);
    tick();
    chk("and popped",    32'(out_valid), 32'd0);
    chk("and op_count",  32'(op_count),  32'd1);
    chk("and hold out",  32'(out),       32'h0001);

    // idle input changes are ignored
    x = 16'hFFFF; ctrl = ALU_NEG1;
    tick();
    chk("idle out",      32'(out),       32'h0001);
    chk("idle vld",      32'(out_valid), 32'd0);

    // back-to-back full throughput
    beat(ALU_XPLUSY, 16'h0005, 16'h0003);
    tick();
    chk("plus out",  32'(out), 32'h0008);
    chk("plus ng",   32'(ng),  32'd0);
    chk("plus rdy",  32'(in_ready), 32'd1);
    ctrl = ALU_XMINUSY;
    tick();
    chk("xmy out",   32'(out), 32'h0002);
    chk("xmy ng",    32'(ng),  32'd0);
    chk("xmy rdy",   32'(in_ready), 32'd1);
    ctrl = ALU_YMINUSX;
    tick(); in_valid = 1'b0;
    chk("ymx out",   32'(out), 32'hFFFE);
    chk("ymx ng",    32'(ng),  32'd1);
    chk("ymx rdy",   32'(in_ready), 32'd1);
    tick();
    chk("b2b op_count", 32'(op_count), 32'd4);

    // constants
    beat(ALU_ZERO, 16'h1234, 16'h5678);
    tick(); in_valid = 1'b0;
    chk("zero out", 32'(out), 32'h0000);
    chk("zero zr",  32'(zr),  32'd1);
    tick();
    beat(ALU_NEG1, 16'h1234, 16'h5678);
    tick(); in_valid = 1'b0;
    chk("neg1 out", 32'(out), 32'hFFFF);
    chk("neg1 ng",  32'(ng),  32'd1);
    chk("neg1 zr",  32'(zr),  32'd0);
    tick();
    chk("const op_count", 32'(op_count), 32'd6);

    // back-pressure: fill, stall, drain in order
    out_ready = 1'b0;
    beat(ALU_ONE, 16'h0000, 16'h0000);
    tick();
    chk("bp rdy1", 32'(in_ready), 32'd1);
    beat(ALU_X, 16'h1234, 16'h0000);
    tick();
    chk("bp rdy full", 32'(in_ready), 32'd0);
    beat(ALU_Y, 16'h0000, 16'hABCD);
    tick(); tick(); tick();
    chk("bp stall rdy",  32'(in_ready), 32'd0);
    chk("bp stall head", 32'(out),      32'h0001);
    chk("bp op_count",   32'(op_count), 32'd6);
    out_ready = 1'b1;
    tick();
    chk("drain 1234", 32'(out),      32'h1234);
    chk("drain rdy",  32'(in_ready), 32'd1);
    tick(); in_valid = 1'b0;
    // accept + pop with one entry: count stays 1
    chk("sim out",  32'(out),       32'hABCD);
    chk("sim vld",  32'(out_valid), 32'd1);
    chk("sim rdy",  32'(in_ready),  32'd1);
    tick();
    chk("drain empty", 32'(out_valid), 32'd0);
    chk("drain op_count", 32'(op_count), 32'd9);

    // async reset with a full buffer
    out_ready = 1'b0;
    beat(ALU_ONE, 16'h0, 16'h0);
    tick(); tick(); in_valid = 1'b0;
    chk("pre-rst full", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst out_valid", 32'(out_valid), 32'd0);
    chk("arst op_count",  32'(op_count),  32'd0);
    chk("arst in_ready",  32'(in_ready),  32'd0);
    chk("arst out",       32'(out),       32'd0);
    @(negedge clk); reset = 1'b0;
    tick();
    chk("post-rst rdy", 32'(in_ready),  32'd1);
    chk("post-rst vld", 32'(out_valid), 32'd0);

    // op_count wrap
    out_ready = 1'b1;
    beat(ALU_ZERO, 16'h0, 16'h0);
    repeat (65535) @(posedge clk);
    #1 in_valid = 1'b0;
    tick();
    chk("wrap ffff", 32'(op_count), 32'hFFFF);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    chk("wrap zero", 32'(op_count), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
